// File: rtl/advance_conditioner_pkg.sv
// Shared board constants and helpers for the advance button conditioner.
// Default cycle counts are derived from the 50 MHz board clock.
package advance_conditioner_pkg;

  localparam int CLK_HZ = 50_000_000;

  // 20 ms debounce, 500 ms before the first repeat, then 200 ms between repeats.
  localparam int DEFAULT_DEBOUNCE_CYCLES     = CLK_HZ / 50;
  localparam int DEFAULT_REPEAT_DELAY_CYCLES = CLK_HZ / 2;
  localparam int DEFAULT_REPEAT_RATE_CYCLES  = CLK_HZ / 5;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/advance_conditioner_sync_2ff.sv
// Two-flop synchroniser for one asynchronous input; output lags the pin by two clk edges.
// The reset value lets idle-high pins (active-low buttons) come out of reset as inactive.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/advance_conditioner.sv
// Synchronises and debounces the active-low advance button, emitting one clk-wide pulse per
// accepted press (plus optional auto-repeat); pulse lands DEBOUNCE_CYCLES+2 edges after the press.
module advance_conditioner
  import advance_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit REPEAT_EN           = 1'b1,
  parameter int REPEAT_DELAY_CYCLES = DEFAULT_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEFAULT_REPEAT_RATE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic advance,
  output logic advance_pulse,
  output logic advance_level
);

  localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES));

  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE_CYCLES - 1);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_PRESS_DB   = 2'd1;
  localparam logic [1:0] S_HELD       = 2'd2;
  localparam logic [1:0] S_RELEASE_DB = 2'd3;

  logic          sync_out;
  logic          pressed;
  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          phase_rate, phase_rate_nxt;
  logic          pulse_q, pulse_nxt;
  logic          level_q, level_nxt;

  // Resets to released so a held button never looks like a fresh press on reset exit.
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (advance),
    .q    (sync_out)
  );

  assign pressed = ~sync_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      phase_rate <= 1'b0;
      pulse_q    <= 1'b0;
      level_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      phase_rate <= phase_rate_nxt;
      pulse_q    <= pulse_nxt;
      level_q    <= level_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    phase_rate_nxt = phase_rate;
    pulse_nxt      = 1'b0;
    level_nxt      = level_q;
    case (state)
      S_IDLE: begin
        if (pressed) begin
          state_nxt = S_PRESS_DB;
          cnt_nxt   = '0;
        end
      end
      S_PRESS_DB: begin
        if (!pressed) begin
          state_nxt = S_IDLE;
        end else if (cnt == DB_LAST) begin
          state_nxt      = S_HELD;
          pulse_nxt      = 1'b1;
          level_nxt      = 1'b1;
          cnt_nxt        = '0;
          phase_rate_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_HELD: begin
        if (!pressed) begin
          state_nxt = S_RELEASE_DB;
          cnt_nxt   = '0;
        end else if (!REPEAT_EN) begin
          cnt_nxt = '0;
        end else if (cnt == (phase_rate ? RATE_LAST : DELAY_LAST)) begin
          pulse_nxt      = 1'b1;
          cnt_nxt        = '0;
          phase_rate_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RELEASE_DB: begin
        // A short release glitch returns to HELD without re-pulsing; repeat phase survives.
        if (pressed) begin
          state_nxt = S_HELD;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = S_IDLE;
          level_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    advance_pulse = pulse_q;
    advance_level = level_q;
  end

endmodule

// File: tb/tb_advance_conditioner.sv
// Drives two conditioners (repeat off / on) from one button and compares them each cycle
// against a run-length model of the debounce and repeat rules.
module tb_advance_conditioner;

  localparam int DB    = 4;
  localparam int DELAY = 10;
  localparam int RATE  = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic advance = 1'b1;
  logic pulse0, level0, pulse1, level1;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  always #20 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  advance_conditioner #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1'b0),
    .REPEAT_DELAY_CYCLES(DELAY), .REPEAT_RATE_CYCLES(RATE)
  ) dut0 (
    .clk(clk), .reset(reset), .advance(advance),
    .advance_pulse(pulse0), .advance_level(level0)
  );

  advance_conditioner #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1'b1),
    .REPEAT_DELAY_CYCLES(DELAY), .REPEAT_RATE_CYCLES(RATE)
  ) dut1 (
    .clk(clk), .reset(reset), .advance(advance),
    .advance_pulse(pulse1), .advance_level(level1)
  );

  // Model: the debounced level flips once the synchronised input has disagreed with it for
  // DB+1 consecutive edges; a repeat fires after an unbroken run of held edges.
  typedef struct {
    logic a1;
    logic a2;
    logic level;
    logic pulse;
    int   run;
    int   rep;
    logic first;
  } model_t;

  function automatic model_t model_reset();
    model_t m;
    m.a1 = 1'b1; m.a2 = 1'b1; m.level = 1'b0; m.pulse = 1'b0;
    m.run = 0; m.rep = 0; m.first = 1'b1;
    return m;
  endfunction

  function automatic model_t model_step(input model_t m, input logic adv, input bit rep_en);
    model_t n;
    logic   pressed;
    n       = m;
    pressed = ~m.a2;
    n.a2    = m.a1;
    n.a1    = adv;
    n.pulse = 1'b0;
    n.run   = (pressed != m.level) ? m.run + 1 : 0;
    if (n.run == DB + 1) begin
      n.level = pressed;
      n.run   = 0;
      if (pressed) begin
        n.pulse = 1'b1;
        n.rep   = 0;
        n.first = 1'b1;
      end
    end else if (m.level && rep_en) begin
      if (!pressed) begin
        n.rep = -1;
      end else begin
        n.rep = m.rep + 1;
        if (n.rep == (m.first ? DELAY : RATE)) begin
          n.pulse = 1'b1;
          n.rep   = 0;
          n.first = 1'b0;
        end
      end
    end
    return n;
  endfunction

  model_t m0, m1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m0 <= model_reset();
      m1 <= model_reset();
    end else begin
      m0 <= model_step(m0, advance, 1'b0);
      m1 <= model_step(m1, advance, 1'b1);
    end
  end

  int   pq0[$];
  int   pq1[$];
  int   fall0 = -1;
  logic prev_level0 = 1'b0;
  logic level_seen = 1'b0;
  logic level_drop = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("pulse_norepeat", {31'd0, pulse0}, {31'd0, m0.pulse});
    chk("level_norepeat", {31'd0, level0}, {31'd0, m0.level});
    chk("pulse_repeat", {31'd0, pulse1}, {31'd0, m1.pulse});
    chk("level_repeat", {31'd0, level1}, {31'd0, m1.level});
    if (pulse0) pq0.push_back(edge_n);
    if (pulse1) pq1.push_back(edge_n);
    if (prev_level0 && !level0) fall0 = edge_n;
    if (level0 || level1) level_seen = 1'b1;
    if (!level0) level_drop = 1'b1;
    prev_level0 = level0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      check_outputs();
    end
  endtask

  initial begin
    int k;
    int r;

    // Reset and idle.
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_pulse0", {31'd0, pulse0}, 32'd0);
    chk("reset_level0", {31'd0, level0}, 32'd0);
    chk("reset_pulse1", {31'd0, pulse1}, 32'd0);
    chk("reset_level1", {31'd0, level1}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step(20);
    chk("idle_pulses", pq0.size() + pq1.size(), 32'd0);

    // Hold for 40 cycles: one pulse without repeat, seven with repeat.
    pq0.delete(); pq1.delete();
    k = edge_n + 1;
    advance = 1'b0;
    step(40);
    r = edge_n + 1;
    advance = 1'b1;
    step(12);
    chk("single_pulse_count", pq0.size(), 32'd1);
    if (pq0.size() > 0) chk("single_pulse_edge", pq0[0], k + DB + 2);
    chk("repeat_pulse_count", pq1.size(), 32'd7);
    for (int i = 0; i < 7 && i < pq1.size(); i++)
      chk("repeat_pulse_edge", pq1[i], (i == 0) ? k + 6 : (i == 1) ? k + 16 : k + 16 + 5 * (i - 1));
    chk("release_fall_edge", fall0, r + DB + 2);

    // Bounce shorter than the debounce window.
    pq0.delete(); pq1.delete();
    level_seen = 1'b0;
    advance = 1'b0; step(2);
    advance = 1'b1; step(1);
    advance = 1'b0; step(3);
    advance = 1'b1; step(10);
    chk("bounce_pulses", pq0.size() + pq1.size(), 32'd0);
    chk("bounce_level", {31'd0, level_seen}, 32'd0);

    // Release glitch while held.
    advance = 1'b0;
    step(8);
    pq0.delete();
    level_drop = 1'b0;
    advance = 1'b1; step(2);
    advance = 1'b0; step(8);
    chk("glitch_pulses", pq0.size(), 32'd0);
    chk("glitch_level_drop", {31'd0, level_drop}, 32'd0);

    // Asynchronous reset while pressed, then re-debounce with the button still held.
    chk("pre_reset_level", {31'd0, level0}, 32'd1);
    #5 reset = 1'b1;
    #1;
    chk("async_reset_pulse0", {31'd0, pulse0}, 32'd0);
    chk("async_reset_level0", {31'd0, level0}, 32'd0);
    chk("async_reset_pulse1", {31'd0, pulse1}, 32'd0);
    chk("async_reset_level1", {31'd0, level1}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pq0.delete();
    step(10);
    chk("post_reset_pulses", pq0.size(), 32'd1);
    advance = 1'b1;
    step(12);

    // Fast chatter never qualifies; a clean hold afterwards does.
    pq0.delete(); pq1.delete();
    fork
      begin
        #5;
        repeat (80) begin
          advance = ~advance;
          #100;
        end
      end
      step(200);
    join
    step(10);
    chk("chatter_pulses", pq0.size() + pq1.size(), 32'd0);
    advance = 1'b0; step(10);
    advance = 1'b1; step(10);
    chk("after_chatter_pulses0", pq0.size(), 32'd1);
    chk("after_chatter_pulses1", pq1.size(), 32'd1);

    // Random holds, releases and occasional resets against the model.
    repeat (80) begin
      advance = 1'($urandom_range(0, 1));
      step($urandom_range(1, 25));
      if ($urandom_range(0, 15) == 0) begin
        #7 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    advance = 1'b1;
    step(15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
